// File: rtl/shift_mult_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shift_mult_ctrl_pkg
// Shared definitions for the serial shift-multiplier sequencing controller:
//   - WIDTH_DEF : default operand width (product is 2*WIDTH_DEF bits)
//   - state_t   : controller FSM state encoding, also exported for debug
// ---------------------------------------------------------------------------
package shift_mult_ctrl_pkg;

  localparam int WIDTH_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage : shift_mult_ctrl_pkg

// File: rtl/shift_mult_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointer -> 0)
//   req[1:0]  : request bits
//   adv       : a grant was taken this cycle; move the pointer
//   gnt[1:0]  : one-hot grant, or zero when nothing is requested
//   id        : index of the granted requester (0 when none)
// A lone requester always wins; the pointer only breaks ties. After an
// advance the pointer favours the requester that was not granted.
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt,
  output logic       id
);

  logic r_ptr;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    case (req)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
      2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
      default: w_gnt = 2'b00;
    endcase
  end

  assign gnt = w_gnt;
  assign id  = w_gnt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (adv) begin
      r_ptr <= ~w_gnt[1];
    end
  end

endmodule : rr_arb2

// File: rtl/shift_mult_ctrl.sv
// ---------------------------------------------------------------------------
// shift_mult_ctrl
// Sequencing controller for an external serial left-shift multiplier.
// Arbitrates between two requesters, clears the datapath, feeds the
// multiplier operand one bit per cycle (LSB first) while holding the
// multiplicand, captures the product and returns it tagged with the id.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester request handshake (2 bits)
//   req_x0/1, req_y0/1    : multiplier / multiplicand per requester
//   dp_load, dp_x, dp_y   : datapath clear, current X bit, multiplicand
//   dp_p                  : datapath accumulated product (2*WIDTH)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_p, rsp_id         : product and issuing requester
//   busy                  : controller not in IDLE
//   dbg_state             : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is only raised in IDLE and only for the arbiter's
// grant; it depends on req_valid and the state register, never on
// rsp_ready. rsp_valid stays high with rsp_p/rsp_id frozen until rsp_ready.
// ---------------------------------------------------------------------------
module shift_mult_ctrl
  import shift_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [WIDTH-1:0]     req_x0,
  input  logic [WIDTH-1:0]     req_x1,
  input  logic [WIDTH-1:0]     req_y0,
  input  logic [WIDTH-1:0]     req_y1,
  output logic                 dp_load,
  output logic                 dp_x,
  output logic [WIDTH-1:0]     dp_y,
  input  logic [2*WIDTH-1:0]   dp_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_p,
  output logic                 rsp_id,
  output logic                 busy,
  output state_t               dbg_state
);

  localparam int K_W = $clog2(WIDTH + 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(WIDTH - 1);

  state_t               r_state;
  logic [K_W-1:0]       r_k;
  logic [WIDTH-1:0]     r_x;
  logic [WIDTH-1:0]     r_y;
  logic                 r_id;
  logic                 r_dp_load;
  logic                 r_dp_x;
  logic [WIDTH-1:0]     r_dp_y;
  logic                 r_rsp_valid;
  logic [2*WIDTH-1:0]   r_rsp_p;
  logic                 r_rsp_id;

  logic [1:0]           w_arb_req;
  logic [1:0]           w_gnt;
  logic                 w_gnt_id;
  logic                 w_accept;
  logic [K_W-1:0]       w_k_next;

  // Requests are only visible to the arbiter in IDLE, so ready is zero
  // whenever busy and the pointer can only advance on a real accept.
  assign w_arb_req = (r_state == ST_IDLE) ? req_valid : 2'b00;
  assign w_accept  = |w_gnt;
  assign w_k_next  = r_k + K_W'(1);

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (w_arb_req),
    .adv (w_accept),
    .gnt (w_gnt),
    .id  (w_gnt_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_id        <= 1'b0;
      r_dp_load   <= 1'b0;
      r_dp_x      <= 1'b0;
      r_dp_y      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_p     <= '0;
      r_rsp_id    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_x       <= w_gnt_id ? req_x1 : req_x0;
            r_y       <= w_gnt_id ? req_y1 : req_y0;
            r_id      <= w_gnt_id;
            r_dp_load <= 1'b1;
            r_dp_x    <= 1'b0;
            r_dp_y    <= w_gnt_id ? req_y1 : req_y0;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Outputs are registered, so the first X bit is staged here.
          r_dp_load <= 1'b0;
          r_dp_x    <= r_x[0];
          r_k       <= '0;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (r_k == K_LAST) begin
            r_dp_x  <= 1'b0;
            r_k     <= '0;
            r_state <= ST_CAPTURE;
          end else begin
            r_dp_x  <= r_x[w_k_next];
            r_k     <= w_k_next;
          end
        end
        ST_CAPTURE: begin
          // The last shift edge has landed, dp_p now holds the full product.
          r_rsp_p     <= dp_p;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_dp_y      <= '0;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = w_gnt;
  assign dp_load   = r_dp_load;
  assign dp_x      = r_dp_x;
  assign dp_y      = r_dp_y;
  assign rsp_valid = r_rsp_valid;
  assign rsp_p     = r_rsp_p;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule : shift_mult_ctrl

// File: tb/tb_shift_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_mult_ctrl
// Directed bench for shift_mult_ctrl. Includes a behavioural model of the
// external serial left-shift datapath: dp_load clears product and bit
// counter; otherwise each edge adds (dp_y << counter) when dp_x is set and
// advances the counter.
// ---------------------------------------------------------------------------
module tb_shift_mult_ctrl;
  import shift_mult_ctrl_pkg::*;

  localparam int W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [W-1:0]     req_x0, req_x1, req_y0, req_y1;
  logic             dp_load;
  logic             dp_x;
  logic [W-1:0]     dp_y;
  logic [2*W-1:0]   dp_p;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2*W-1:0]   rsp_p;
  logic             rsp_id;
  logic             busy;
  state_t           dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // clock / reset
  always #5 clk = ~clk;

  shift_mult_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x0    (req_x0),
    .req_x1    (req_x1),
    .req_y0    (req_y0),
    .req_y1    (req_y1),
    .dp_load   (dp_load),
    .dp_x      (dp_x),
    .dp_y      (dp_y),
    .dp_p      (dp_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // external datapath model
  logic [2*W-1:0] m_p = '0;
  logic [3:0]     m_k = '0;
  always @(posedge clk) begin
    if (dp_load) begin
      m_p <= '0;
      m_k <= '0;
    end else begin
      if (dp_x) m_p <= m_p + ({{W{1'b0}}, dp_y} << m_k);
      m_k <= m_k + 4'd1;
    end
  end
  assign dp_p = m_p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called just after a negedge in an IDLE cycle; returns just after the
  // accepting edge. Requesters other than the granted one keep their valid.
  task automatic start_op(input logic [1:0] mask, input int gid,
                          input logic [W-1:0] x, input logic [W-1:0] y);
    if (gid == 0) begin req_x0 = x; req_y0 = y; end
    else          begin req_x1 = x; req_y1 = y; end
    req_valid = mask;
    #1;
    check("req_ready_grant", 32'(req_ready), 32'd1 << gid);
    check("busy_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    req_valid = mask & ~(2'(1) << gid);
  endtask

  // Full operation; rsp_ready is low for hold+1 RESP cycles when hold>0.
  task automatic run_op(input logic [1:0] mask, input int gid,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input int exp_p, input int hold);
    rsp_ready = (hold == 0);
    start_op(mask, gid, x, y);
    @(negedge clk);
    check("load_pulse", 32'(dp_load), 32'd1);
    check("load_dp_x", 32'(dp_x), 32'd0);
    check("load_dp_y", 32'(dp_y), 32'(y));
    check("load_busy", 32'(busy), 32'd1);
    check("load_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("shift_load", 32'(dp_load), 32'd0);
      check("shift_dp_x", 32'(dp_x), 32'(x[i]));
      check("shift_dp_y", 32'(dp_y), 32'(y));
      check("shift_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    check("capture_rsp_valid", 32'(rsp_valid), 32'd0);
    check("capture_dp_x", 32'(dp_x), 32'd0);
    check("capture_load", 32'(dp_load), 32'd0);
    @(negedge clk);
    check("resp_valid", 32'(rsp_valid), 32'd1);
    check("resp_p", 32'(rsp_p), 32'(exp_p));
    check("resp_id", 32'(rsp_id), 32'(gid));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_p", 32'(rsp_p), 32'(exp_p));
      check("hold_id", 32'(rsp_id), 32'(gid));
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("after_resp_valid", 32'(rsp_valid), 32'd0);
    check("after_resp_busy", 32'(busy), 32'd0);
    check("after_resp_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_dp_load"}, 32'(dp_load), 32'd0);
    check({tag, "_dp_x"}, 32'(dp_x), 32'd0);
    check({tag, "_dp_y"}, 32'(dp_y), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_p"}, 32'(rsp_p), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // requester 0: 6*5 with trace 0,1,1,0,0,0
    run_op(2'b01, 0, 6'd6, 6'd5, 30, 0);
    // corner products
    run_op(2'b01, 0, 6'd63, 6'd63, 3969, 0);
    run_op(2'b01, 0, 6'd0, 6'd63, 0, 0);
    run_op(2'b01, 0, 6'd63, 6'd0, 0, 0);

    // both valid right after reset: pointer 0 picks req 0 first
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_x1 = 6'd7; req_y1 = 6'd9;
    run_op(2'b11, 0, 6'd3, 6'd4, 12, 0);
    run_op(2'b10, 1, 6'd7, 6'd9, 63, 0);

    // response back-pressure: rsp_ready low for 5 RESP cycles
    run_op(2'b01, 0, 6'd5, 6'd7, 35, 4);

    // lone requester 1, three back-to-back
    run_op(2'b10, 1, 6'd11, 6'd13, 143, 0);
    run_op(2'b10, 1, 6'd1, 6'd42, 42, 0);
    run_op(2'b10, 1, 6'd40, 6'd33, 1320, 0);

    // reset during third SHIFT cycle of 21*10
    rsp_ready = 1'b1;
    start_op(2'b01, 0, 6'd21, 6'd10);
    @(negedge clk);              // LOAD
    repeat (3) @(negedge clk);   // SHIFT cycles 1..3
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("abort");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
    run_op(2'b01, 0, 6'd2, 6'd3, 6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_shift_mult_ctrl

// File: doc/shift_mult_ctrl.md
# shift_mult_ctrl

Sequencing controller for the serial left-shift multiplier datapath. It arbitrates round-robin between two requesters that each present a WIDTH-bit operand pair. It drives the datapath's clear (dp_load), per-cycle multiplier bit (dp_x) and multiplicand (dp_y), and feeds one X bit per cycle, LSB first. It captures the 2·WIDTH-bit product and returns it, tagged with the requester id, through a valid/ready response port. It sits between the two client blocks and the single shared multiplier datapath.

## Interface
- WIDTH, 6, operand width; the datapath product width is 2·WIDTH.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  2  request valid, one bit per requester (index 0, 1)
- req_ready  out  2  request accepted this cycle, per requester
- req_x0, req_x1  in  WIDTH  multiplier operand per requester
- req_y0, req_y1  in  WIDTH  multiplicand operand per requester
- dp_load  out  1  datapath clear (zeroes product and bit counter on next edge)
- dp_x  out  1  current multiplier bit to datapath
- dp_y  out  WIDTH  multiplicand to datapath, held stable for a whole operation
- dp_p  in  2·WIDTH  datapath accumulated product
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_p  out  2·WIDTH  product
- rsp_id  out  1  requester that issued the operation
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, SHIFT, CAPTURE, RESP.
- IDLE:
  - grant = requester selected by the round-robin pointer among asserted req_valid bits.
  - req_ready[grant] = 1 combinationally; all other req_ready bits are 0.
  - On accept: latch x, y and id; go to LOAD.
- LOAD (1 cycle): dp_load = 1, dp_x = 0; go to SHIFT with bit index k = 0.
- SHIFT (WIDTH cycles): dp_x = x_latched[k], dp_load = 0; k increments each cycle. After k = WIDTH−1, go to CAPTURE.
- CAPTURE (1 cycle): rsp_p <= dp_p, rsp_id <= latched id; go to RESP.
- RESP: rsp_valid = 1. Leave when rsp_valid & rsp_ready, back to IDLE. rsp_p and rsp_id are held stable while waiting.
- Arbitration:
  - The pointer resets to 0.
  - After each accept, the pointer moves to the requester that was not granted.
  - If only one requester is valid, it is granted regardless of the pointer.
- No request is accepted outside IDLE; req_ready = 0 whenever busy.
- dp_y = latched y during LOAD/SHIFT/CAPTURE, and 0 in IDLE.
- k is a $clog2(WIDTH+1)-bit counter. The product is exact for all unsigned operands; 2·WIDTH bits means no overflow.

## Timing
- Accept at edge n (IDLE→LOAD), then:
  - LOAD during cycle n+1
  - SHIFT during cycles n+2 … n+WIDTH+1
  - CAPTURE during cycle n+WIDTH+2
  - rsp_valid high from cycle n+WIDTH+3
- Latency is 9 cycles for WIDTH=6.
- Minimum initiation interval is WIDTH+4 cycles (the RESP handshake takes 1 cycle). IDLE is re-entered the cycle after the rsp handshake, and a new accept is possible in that IDLE cycle.
- rsp_ready held high is not a combinational path to req_ready.
- Reset values:
  - state = IDLE, pointer = 0, k = 0
  - rsp_valid = 0, rsp_p = 0, rsp_id = 0
  - dp_load = 0, dp_x = 0, dp_y = 0, busy = 0, req_ready = 0
- rst during any state aborts the operation in the same edge. The in-flight result is discarded, never presented, and the requester is not notified. The next operation's LOAD clears any partial datapath sum.
- req_valid dropping after accept has no effect, because operands are latched.

## Structure
- Shared package: state encoding (IDLE, LOAD, SHIFT, CAPTURE, RESP) and default WIDTH constant.
- One sub-module: rr_arb2, the 2-requester round-robin arbiter. It has inputs req[1:0] and adv; outputs gnt[1:0] one-hot or zero, and id. It updates its pointer on adv.
- The datapath is external and connected at top level.

## Test plan
- Requester 0 sends x=6, y=5 with rsp_ready=1 → rsp_valid after 9 cycles with rsp_p=30, rsp_id=0; exactly one LOAD pulse followed by dp_x sequence 0,1,1,0,0,0.
- x=63, y=63 → rsp_p=3969; x=0, y=63 → rsp_p=0; x=63, y=0 → rsp_p=0.
- Both req_valid high right after reset, with (x=3, y=4) on req 0 and (x=7, y=9) on req 1 → first result 12 with id 0, second 63 with id 1. req_ready never asserts while busy.
- rsp_ready held low for 5 cycles in RESP → rsp_valid, rsp_p and rsp_id stay stable; no req_ready asserted; the result is released on the first cycle rsp_ready is high.
- Requester 1 only, three back-to-back requests → all three granted to requester 1; the pointer alternation does not starve a lone requester.
- rst pulsed during the 3rd SHIFT cycle of x=21, y=10 → next cycle state is IDLE with all outputs at reset values and no rsp_valid. A following request x=2, y=3 returns 6.
